button_events: RTL
==================

BUTTON_EVENTS -- requirements
Module: button_events

Interface
REQ-001 SHALL provide parameter COUNTER_WIDTH, default 16, width of the hold-time counter.
REQ-002 SHALL provide parameter LONG_CYCLES, default 50000, press-to-long-press distance in clk cycles; legal range 2..2^COUNTER_WIDTH-1.
REQ-003 SHALL provide parameter REPEAT_CYCLES, default 10000, long-press-to-repeat and repeat-to-repeat distance in clk cycles; legal range 2..2^COUNTER_WIDTH-1.
REQ-004 SHALL provide parameter REPEAT_EN, default 1; 0 disables repeat pulses.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-007 in  input  1  debounced button level, already synchronous to clk; 1 = pressed.
REQ-008 held  output  1  registered copy of in; 1 while the button is considered pressed.
REQ-009 press  output  1  one-cycle pulse on a press.
REQ-010 release  output  1  one-cycle pulse on a release.
REQ-011 long_press  output  1  one-cycle pulse when the hold reaches LONG_CYCLES.
REQ-012 repeat  output  1  one-cycle pulse every REPEAT_CYCLES during a long hold.

Function
REQ-013 SHALL implement states IDLE, PRESSED and LONG; all outputs SHALL be registered.
REQ-014 held SHALL equal in delayed by exactly one clk cycle.
REQ-015 Rising edge SHALL be defined as in=1 while held=0; falling edge as in=0 while held=1.
REQ-016 On a rising edge in IDLE: next cycle press=1, state PRESSED, counter=0.
REQ-017 In PRESSED with in=1: counter increments by 1 per cycle; when counter==LONG_CYCLES-1, next cycle long_press=1, state LONG, counter=0.
REQ-018 long_press SHALL therefore assert exactly LONG_CYCLES cycles after the press pulse.
REQ-019 In LONG with in=1 and REPEAT_EN=1: counter increments; when counter==REPEAT_CYCLES-1, next cycle repeat=1, counter=0, state stays LONG.
REQ-020 First repeat SHALL assert exactly REPEAT_CYCLES cycles after long_press; subsequent repeats REPEAT_CYCLES apart, indefinitely.
REQ-021 With REPEAT_EN=0: LONG holds; counter frozen at 0; repeat never asserts.
REQ-022 On a falling edge in PRESSED or LONG: next cycle release=1, state IDLE, counter=0.
REQ-023 Falling edge in the same cycle a long_press or repeat threshold is reached: release wins; long_press/repeat SHALL NOT assert.
REQ-024 Counter SHALL never wrap; it is cleared before reaching LONG_CYCLES or REPEAT_CYCLES.
REQ-025 At most one of press, release, long_press and repeat SHALL be high in any cycle.
REQ-026 A one-cycle in=1 glitch SHALL produce press in one cycle and release in the next; no long_press.
REQ-027 in=0 in IDLE and in=1 in PRESSED/LONG without a threshold SHALL produce no pulses.

Reset
REQ-028 rst_n=0 SHALL immediately, without waiting for clk, force state IDLE, counter 0, and held, press, release, long_press and repeat to 0.
REQ-029 Reset mid-hold SHALL abandon the hold silently; no release pulse on reset or on exit.
REQ-030 If in=1 at reset deassertion: first active edge sees a rising edge; next cycle press=1 (treated as a new press).
REQ-031 Deassertion SHALL be used synchronously; first state change no earlier than the first rising clk edge after rst_n rises.

Verification (LONG_CYCLES=10, REPEAT_CYCLES=4, REPEAT_EN=1 unless stated)
REQ-032 in high 5 cycles then low -> press at t+1, release at t+6, no long_press, no repeat.
REQ-033 in high 30 cycles -> press at t+1, long_press at t+11, repeat at t+15, t+19, t+23, t+27, release at t+31.
REQ-034 Release landing on the long threshold cycle (in high exactly 10 cycles) -> press at t+1, release at t+11, long_press never asserted.
REQ-035 REPEAT_EN=0, in high 30 cycles -> press at t+1, long_press at t+11, zero repeats, release at t+31.
REQ-036 rst_n pulsed low asynchronously at t+13 of a 30-cycle hold with in still high -> all outputs 0 at once, no release pulse, press one cycle after the first rising clk edge following rst_n rising.
REQ-037 All scenarios: check REQ-025 (at most one pulse per cycle) and held == in delayed one cycle, every cycle.

Source files
------------

// File: rtl/button_events.sv
`default_nettype none
// ============================================================================
// Module      : button_events
// Description : Turns a debounced, clk-synchronous button level into press,
//               release, long-press and auto-repeat one-cycle pulses, plus a
//               registered copy of the level.
// Revision    : 1.0 - initial release
// ============================================================================
// The release and repeat pulses are named release_pulse and repeat_pulse
// because "release" and "repeat" are reserved words in SystemVerilog.
module button_events #(
    parameter int COUNTER_WIDTH = 16,
    parameter int LONG_CYCLES   = 50000,
    parameter int REPEAT_CYCLES = 10000,
    parameter int REPEAT_EN     = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic held,
    output logic press,
    output logic release_pulse,
    output logic long_press,
    output logic repeat_pulse
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESSED = 2'd1,
        S_LONG    = 2'd2
    } state_t;

    // Terminal counts: the threshold pulse is scheduled one cycle before the
    // distance elapses, so it lands exactly LONG/REPEAT_CYCLES after the
    // previous event pulse.
    localparam logic [COUNTER_WIDTH-1:0] c_long_last   = COUNTER_WIDTH'(LONG_CYCLES - 1);
    localparam logic [COUNTER_WIDTH-1:0] c_repeat_last = COUNTER_WIDTH'(REPEAT_CYCLES - 1);
    localparam logic [COUNTER_WIDTH-1:0] c_one         = COUNTER_WIDTH'(1);
    localparam logic                     c_repeat_en   = (REPEAT_EN != 0);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [COUNTER_WIDTH-1:0] r_count;
    logic [COUNTER_WIDTH-1:0] w_count_nxt;
    logic                     r_held;
    logic                     r_press;
    logic                     r_release;
    logic                     r_long;
    logic                     r_repeat;
    logic                     w_press_nxt;
    logic                     w_release_nxt;
    logic                     w_long_nxt;
    logic                     w_repeat_nxt;
    logic                     w_rise;
    logic                     w_fall;

    // Edges are judged against the registered level, so held and the edge
    // detector can never disagree.
    assign w_rise = in & ~r_held;
    assign w_fall = ~in & r_held;

    // State, counter and all outputs registered; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_held    <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
            r_repeat  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_held    <= in;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
            r_long    <= w_long_nxt;
            r_repeat  <= w_repeat_nxt;
        end
    end

    // Next-state and next-pulse logic; a falling edge always beats a threshold.
    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_long_nxt    = 1'b0;
        w_repeat_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_press_nxt = 1'b1;
                    w_state_nxt = S_PRESSED;
                    w_count_nxt = '0;
                end
            end
            S_PRESSED: begin
                if (w_fall) begin
                    w_release_nxt = 1'b1;
                    w_state_nxt   = S_IDLE;
                    w_count_nxt   = '0;
                end else if (in) begin
                    if (r_count == c_long_last) begin
                        w_long_nxt  = 1'b1;
                        w_state_nxt = S_LONG;
                        w_count_nxt = '0;
                    end else begin
                        w_count_nxt = r_count + c_one;
                    end
                end
            end
            S_LONG: begin
                if (w_fall) begin
                    w_release_nxt = 1'b1;
                    w_state_nxt   = S_IDLE;
                    w_count_nxt   = '0;
                end else if (in && c_repeat_en) begin
                    if (r_count == c_repeat_last) begin
                        w_repeat_nxt = 1'b1;
                        w_count_nxt  = '0;
                    end else begin
                        w_count_nxt = r_count + c_one;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

    assign held          = r_held;
    assign press         = r_press;
    assign release_pulse = r_release;
    assign long_press    = r_long;
    assign repeat_pulse  = r_repeat;

endmodule
`default_nettype wire
